micro_ucr_nonce_search: RTL and testbench
=========================================

Name: micro_ucr_nonce_search

Overview:
Sequential nonce-search engine for the micro_ucr hash. It latches a 96-bit block header, then iterates the 32-bit nonce from nonce_start to nonce_limit. For each nonce it computes the 24-bit micro_ucr hash with one compression round per cycle, and stops on the first nonce whose hash meets the target. It is the initiator and consumer of the hash function: it generates nonces and judges hashes.

Parameters:
H0, 8'h01, initial/final chaining value a
H1, 8'h89, initial/final chaining value b
H2, 8'hFE, initial/final chaining value c
K1, 8'h99, round constant, rounds 0..16
K2, 8'hA1, round constant, rounds 17..31

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin search; sampled only in IDLE or DONE
bloque_bytes  in  96  block header; byte i = bloque_bytes[i*8+:8]
nonce_start  in  32  first nonce tried
nonce_limit  in  32  last nonce tried (inclusive)
target  in  16  success when hash[23:8] <= target
busy  out  1  high in LOAD/ROUND/CHECK
done  out  1  high in DONE
found  out  1  valid when done; 1 = success
nonce_out  out  32  nonce of the last hash checked
hash_out  out  24  hash of nonce_out

Behaviour:
- Reset (synchronous, active-high, clk edge), outputs and state:
  - state=IDLE; busy=0, done=0, found=0, nonce_out=0, hash_out=0.
  - Reset asserted mid-search aborts the search the same edge. No partial result is kept.
- Start and input latching:
  - start=1 in IDLE or DONE latches bloque_bytes, nonce_start, nonce_limit and target. Current nonce = nonce_start. Go to LOAD; done/found clear.
  - start is ignored while busy. Input changes after the latch have no effect.
- LOAD (1 cycle): a=H0, b=H1, c=H2; round counter r=0; schedule sub-module loaded with header bytes and the current nonce.
- Message schedule:
  - W[0..11] = header bytes.
  - W[12..15] = nonce[(i-12)*8+:8].
  - W[i] = W[i-3] | (W[i-9] ^ W[i-14]) for i = 16..31.
  - W[r] is produced in round order, one per cycle.
- ROUND (32 cycles, r = 0..31), all arithmetic mod 256:
  - k = K1 if r <= 16, else K2.
  - x = a ^ b if r <= 16, else a | b.
  - a' = b ^ c.
  - b' = {c[3:0], 4'h0} (left shift, truncated).
  - c' = x + k + W[r].
  - After r=31, go to CHECK.
- CHECK (1 cycle):
  - hash = {H0+a, H1+b, H2+c}, each byte mod 256. Register hash_out=hash and nonce_out=current nonce.
  - If hash[23:8] <= target: found=1, go to DONE.
  - Else if nonce == nonce_limit: found=0, go to DONE.
  - Else nonce+1, go to LOAD.
- Timing:
  - Latency: 34 cycles per nonce (LOAD + 32 ROUND + CHECK).
  - Result visible with done=1 exactly 34*N cycles after the start edge, where N = number of nonces tried.
- Boundary cases:
  - nonce_start > nonce_limit: only nonce_start is tried, then DONE.
  - nonce_limit = 32'hFFFFFFFF: the nonce never wraps; the search ends on that nonce.
  - DONE holds all outputs until reset or a new start.

Decomposition:
- Shared package micro_ucr_pkg holds:
  - Constants: H0/H1/H2, K1/K2, the round-switch index 16, ROUNDS=32, HDR_BYTES=12.
  - State enum: IDLE/LOAD/ROUND/CHECK/DONE.
  - Function round_step(a, b, c, k, w, r), shared with the combinational hasher and with the testbench golden model.
- One sub-module, micro_ucr_sched: a 16-byte shift-window message scheduler emitting W[r] per cycle. Interface: load, advance, w_out.

Test Plan:
- Reset mid-ROUND (assert reset at cycle 10 of a search) -> next edge: busy=0, done=0, found=0, nonce_out=0, hash_out=0. A new start behaves as from power-up.
- target=16'hFFFF, nonce_start=32'h0000_0005 -> done at cycle 34, found=1, nonce_out=5, hash_out equals the golden model for (header, 5).
- target=16'h0000, nonce_start=0, nonce_limit=2, header chosen so the golden model shows no match -> done at cycle 102, found=0, nonce_out=2.
- Golden-model-selected header, first match at nonce 3 of range 0..10 -> done at cycle 136, found=1, nonce_out=3, hash_out matches the model.
- nonce_start=nonce_limit=32'hFFFFFFFF, no match -> done at 34, found=0, nonce_out=32'hFFFFFFFF, no wrap to 0.
- start pulsed at cycle 20 while busy, with changed inputs -> ignored; result matches the originally latched inputs.

Source files
------------

// File: rtl/micro_ucr_pkg.sv
// Shared definitions for the micro_ucr nonce-search engine.
//   - chaining values H0..H2 and round constants K1/K2
//   - round-count and header-size constants
//   - search FSM state encoding
//   - round_step(): one compression round, shared by the hasher and the bench
package micro_ucr_pkg;

    localparam logic [7:0] H0 = 8'h01;
    localparam logic [7:0] H1 = 8'h89;
    localparam logic [7:0] H2 = 8'hFE;
    localparam logic [7:0] K1 = 8'h99;
    localparam logic [7:0] K2 = 8'hA1;

    localparam int ROUND_SWITCH = 16;  // last round that uses K1 and XOR mixing
    localparam int ROUNDS       = 32;
    localparam int HDR_BYTES    = 12;
    localparam int WIN_BYTES    = 16;  // schedule window: 12 header bytes + 4 nonce bytes

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        CHECK,
        DONE
    } state_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } abc_t;

    function automatic logic [7:0] round_const(input logic [4:0] r);
        return (r <= 5'(ROUND_SWITCH)) ? K1 : K2;
    endfunction

    // One compression round. All sums wrap at 8 bits.
    function automatic abc_t round_step(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] c,
                                        input logic [7:0] k,
                                        input logic [7:0] w,
                                        input logic [4:0] r);
        abc_t       s;
        logic [7:0] x;
        x   = (r <= 5'(ROUND_SWITCH)) ? (a ^ b) : (a | b);
        s.a = b ^ c;
        s.b = {c[3:0], 4'h0};
        s.c = x + k + w;
        return s;
    endfunction

endpackage

// File: rtl/micro_ucr_sched.sv
// Message scheduler for the micro_ucr hash.
// Holds a 16-byte sliding window W[r..r+15]; w_out is always W[r].
//   clk     : rising-edge clock
//   load    : capture header bytes (W[0..11]) and nonce bytes (W[12..15])
//   advance : slide the window by one, appending W[r+16]
//   hdr     : 96-bit block header, byte i = hdr[i*8+:8]
//   nonce   : 32-bit nonce, byte j = nonce[j*8+:8]
//   w_out   : schedule word for the current round
module micro_ucr_sched
    import micro_ucr_pkg::*;
(
    input  logic                   clk,
    input  logic                   load,
    input  logic                   advance,
    input  logic [8*HDR_BYTES-1:0] hdr,
    input  logic [31:0]            nonce,
    output logic [7:0]             w_out
);

    logic [7:0] win_q [WIN_BYTES];
    logic [7:0] win_d [WIN_BYTES];

    always_comb begin
        win_d = win_q;
        if (load) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                win_d[i] = hdr[i*8 +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                win_d[HDR_BYTES + i] = nonce[i*8 +: 8];
            end
        end else if (advance) begin
            for (int i = 0; i < WIN_BYTES - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            // W[r+16] = W[r+13] | (W[r+7] ^ W[r+2]), in window-relative indices.
            win_d[WIN_BYTES - 1] = win_q[13] | (win_q[7] ^ win_q[2]);
        end
    end

    // NOTE: the window is always loaded before it is read, so it has no reset;
    // resetting wide datapath storage only costs routing and buys nothing.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign w_out = win_q[0];

endmodule

// File: rtl/micro_ucr_nonce_search.sv
// Sequential nonce-search engine for the micro_ucr 24-bit hash.
// Latches a header and nonce range on start, hashes one nonce per 34 cycles
// (LOAD + 32 ROUND + CHECK) and stops on the first hash with hash[23:8] <= target
// or after the last nonce of the range.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : begin a search (accepted only in IDLE or DONE)
//   bloque_bytes    : 96-bit block header
//   nonce_start     : first nonce tried
//   nonce_limit     : last nonce tried, inclusive
//   target          : success threshold on hash[23:8]
//   busy            : search in progress (LOAD/ROUND/CHECK)
//   done            : search finished, result held
//   found           : valid with done; 1 = a qualifying nonce was found
//   nonce_out       : nonce of the last hash checked
//   hash_out        : hash of nonce_out
module micro_ucr_nonce_search
    import micro_ucr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [95:0] bloque_bytes,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_limit,
    input  logic [15:0] target,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] nonce_out,
    output logic [23:0] hash_out
);

    // Control state and visible outputs (reset).
    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic [31:0] nonce_out_q, nonce_out_d;
    logic [23:0] hash_out_q, hash_out_d;

    // Search datapath (not reset; always written before use).
    logic [95:0] hdr_q, hdr_d;
    logic [31:0] nonce_q, nonce_d;
    logic [31:0] limit_q, limit_d;
    logic [15:0] target_q, target_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  c_q, c_d;
    logic [4:0]  r_q, r_d;

    logic [7:0]  w;
    abc_t        step;
    logic [7:0]  hash_a, hash_b, hash_c;
    logic [23:0] hash;

    micro_ucr_sched u_sched (
        .clk     (clk),
        .load    (state_q == LOAD),
        .advance (state_q == ROUND),
        .hdr     (hdr_q),
        .nonce   (nonce_q),
        .w_out   (w)
    );

    always_comb begin
        step   = round_step(a_q, b_q, c_q, round_const(r_q), w, r_q);
        hash_a = H0 + a_q;
        hash_b = H1 + b_q;
        hash_c = H2 + c_q;
        hash   = {hash_a, hash_b, hash_c};
    end

    always_comb begin
        // NOTE: every _d starts as its _q so each path through the case assigns
        // every signal; a missing default here would infer a latch.
        state_d     = state_q;
        found_d     = found_q;
        nonce_out_d = nonce_out_q;
        hash_out_d  = hash_out_q;
        hdr_d       = hdr_q;
        nonce_d     = nonce_q;
        limit_d     = limit_q;
        target_d    = target_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        r_d         = r_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    hdr_d    = bloque_bytes;
                    nonce_d  = nonce_start;
                    limit_d  = nonce_limit;
                    target_d = target;
                    found_d  = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                a_d     = H0;
                b_d     = H1;
                c_d     = H2;
                r_d     = '0;
                state_d = ROUND;
            end
            ROUND: begin
                a_d = step.a;
                b_d = step.b;
                c_d = step.c;
                r_d = r_q + 5'd1;
                if (r_q == 5'(ROUNDS - 1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                hash_out_d  = hash;
                nonce_out_d = nonce_q;
                if (hash[23:8] <= target_q) begin
                    found_d = 1'b1;
                    state_d = DONE;
                end else if (nonce_q >= limit_q) begin
                    // '>=' also ends a range whose start lies above its limit
                    // after one nonce, and never lets 32'hFFFFFFFF wrap.
                    found_d = 1'b0;
                    state_d = DONE;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        busy_d = (state_d == LOAD) || (state_d == ROUND) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            nonce_out_q <= '0;
            hash_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            nonce_out_q <= nonce_out_d;
            hash_out_q  <= hash_out_d;
        end
    end

    always_ff @(posedge clk) begin
        hdr_q    <= hdr_d;
        nonce_q  <= nonce_d;
        limit_q  <= limit_d;
        target_q <= target_d;
        a_q      <= a_d;
        b_q      <= b_d;
        c_q      <= c_d;
        r_q      <= r_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign nonce_out = nonce_out_q;
    assign hash_out  = hash_out_q;

endmodule

// File: tb/tb_micro_ucr_nonce_search.sv
// Self-checking bench for micro_ucr_nonce_search: directed scenarios plus
// randomized searches, checked against a behavioural search/hash model and a
// per-cycle timeline of the expected outputs.
module tb_micro_ucr_nonce_search;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [95:0] bloque_bytes;
    logic [31:0] nonce_start;
    logic [31:0] nonce_limit;
    logic [15:0] target;
    logic        busy;
    logic        done;
    logic        found;
    logic [31:0] nonce_out;
    logic [23:0] hash_out;

    int n_checks = 0;
    int n_fail   = 0;

    micro_ucr_nonce_search dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bloque_bytes (bloque_bytes),
        .nonce_start  (nonce_start),
        .nonce_limit  (nonce_limit),
        .target       (target),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .nonce_out    (nonce_out),
        .hash_out     (hash_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [23:0] gold_hash(input logic [95:0] hdr, input logic [31:0] nonce);
        logic [7:0] w [32];
        logic [7:0] a, b, c, x, k, na, nb, nc;
        for (int i = 0; i < 12; i++) w[i] = hdr[i*8 +: 8];
        for (int i = 12; i < 16; i++) w[i] = nonce[(i-12)*8 +: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int r = 0; r < 32; r++) begin
            if (r <= 16) begin x = a ^ b; k = 8'h99; end
            else         begin x = a | b; k = 8'hA1; end
            na = b ^ c;
            nb = c << 4;
            nc = x + k + w[r];
            a = na; b = nb; c = nc;
        end
        na = a + 8'h01; nb = b + 8'h89; nc = c + 8'hFE;
        return {na, nb, nc};
    endfunction

    // Number of nonces tried and the outcome of a whole search.
    function automatic void golden_search(input logic [95:0] hdr, input logic [31:0] ns,
                                          input logic [31:0] nl, input logic [15:0] tgt,
                                          output int n, output logic f);
        logic [31:0] nn;
        logic [23:0] h;
        nn = ns; n = 0; f = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            h = gold_hash(hdr, nn);
            n++;
            if (h[23:8] <= tgt) begin f = 1'b1; break; end
            if (nn >= nl) break;
            nn++;
        end
    endfunction

    // Expected-output timeline, advanced on every rising edge.
    logic        m_valid = 1'b0;
    logic        m_busy, m_done, m_found;
    logic [31:0] m_nonce_o;
    logic [23:0] m_hash_o;
    logic [95:0] m_hdr;
    logic [31:0] m_ns;
    int          m_k, m_n;
    logic        m_f;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_found = 1'b0;
            m_nonce_o = '0; m_hash_o = '0;
        end else if (m_valid && start && !m_busy) begin
            m_hdr = bloque_bytes; m_ns = nonce_start;
            golden_search(bloque_bytes, nonce_start, nonce_limit, target, m_n, m_f);
            m_k = 0; m_busy = 1'b1; m_done = 1'b0; m_found = 1'b0;
        end else if (m_busy) begin
            m_k++;
            if (m_k % 34 == 0) begin
                m_nonce_o = m_ns + 32'(m_k / 34 - 1);
                m_hash_o  = gold_hash(m_hdr, m_nonce_o);
                if (m_k / 34 == m_n) begin
                    m_busy = 1'b0; m_done = 1'b1; m_found = m_f;
                end
            end
        end
    end

    // Single compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_found", 32'(found), 32'(m_found));
            check("cyc_nonce_out", nonce_out, m_nonce_o);
            check("cyc_hash_out", 32'(hash_out), 32'(m_hash_o));
        end
    end

    // ---------------- stimulus ----------------
    // Starts a search and waits for done; optionally pulses start with changed
    // inputs at cycle glitch_at, or asserts reset at cycle reset_at.
    task automatic run(input logic [95:0] hdr, input logic [31:0] ns, input logic [31:0] nl,
                       input logic [15:0] tgt, input int glitch_at, input int reset_at,
                       output int lat);
        int cyc;
        bit fin;
        @(negedge clk);
        bloque_bytes = hdr; nonce_start = ns; nonce_limit = nl; target = tgt; start = 1'b1;
        @(posedge clk);
        cyc = 0; lat = -1; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == glitch_at) begin
                start = 1'b1;
                bloque_bytes = ~hdr; nonce_start = ns + 32'd7;
                nonce_limit = nl + 32'd7; target = ~tgt;
            end
            if (cyc == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_found", 32'(found), 32'd0);
                check("rst_nonce_out", nonce_out, 32'd0);
                check("rst_hash_out", 32'(hash_out), 32'd0);
                reset = 1'b0;
                fin = 1'b1;
            end else if (done) begin
                lat = cyc;
                fin = 1'b1;
            end else if (cyc > 34 * 80) begin
                check("done_timeout", 32'(cyc), 32'(34 * 80));
                fin = 1'b1;
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
    endtask

    function automatic logic [95:0] rand_hdr();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        int          lat, n;
        logic        f, ok;
        logic [95:0] hdr, hdr5;
        logic [15:0] tgt5;
        logic [23:0] h0, h1, h2, h3;
        logic [31:0] ns, nl;
        logic [15:0] tgt;

        reset = 1'b1; start = 1'b0;
        bloque_bytes = '0; nonce_start = '0; nonce_limit = '0; target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hash", 32'(hash_out), 32'd0);
        reset = 1'b0;

        // Hand-computed hash of an all-zero header with nonce 0.
        check("model_pin", 32'(gold_hash('0, 32'd0)), 32'h00C18985);
        run('0, 32'd0, 32'd0, 16'hFFFF, -1, -1, lat);
        check("zero_lat", 32'(lat), 32'd34);
        check("zero_found", 32'(found), 32'd1);
        check("zero_hash", 32'(hash_out), 32'h00C18985);

        // Reset in the middle of ROUND, then a fresh search.
        run(rand_hdr(), 32'd0, 32'd5, 16'h0000, -1, 10, lat);
        hdr = rand_hdr();
        run(hdr, 32'd5, 32'd9, 16'hFFFF, -1, -1, lat);
        check("t_ffff_lat", 32'(lat), 32'd34);
        check("t_ffff_found", 32'(found), 32'd1);
        check("t_ffff_nonce", nonce_out, 32'd5);
        check("t_ffff_hash", 32'(hash_out), 32'(gold_hash(hdr, 32'd5)));

        // Three nonces, no match.
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            hdr = rand_hdr();
            golden_search(hdr, 32'd0, 32'd2, 16'h0000, n, f);
            ok = !f;
        end
        check("nomatch_hdr_sel", 32'(ok), 32'd1);
        run(hdr, 32'd0, 32'd2, 16'h0000, -1, -1, lat);
        check("nomatch_lat", 32'(lat), 32'd102);
        check("nomatch_found", 32'(found), 32'd0);
        check("nomatch_nonce", nonce_out, 32'd2);

        // First match at nonce 3 of 0..10.
        ok = 1'b0; hdr5 = '0; tgt5 = '0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            hdr5 = rand_hdr();
            h0 = gold_hash(hdr5, 32'd0); h1 = gold_hash(hdr5, 32'd1);
            h2 = gold_hash(hdr5, 32'd2); h3 = gold_hash(hdr5, 32'd3);
            tgt5 = h3[23:8];
            ok = (h0[23:8] > tgt5) && (h1[23:8] > tgt5) && (h2[23:8] > tgt5);
        end
        check("match3_hdr_sel", 32'(ok), 32'd1);
        run(hdr5, 32'd0, 32'd10, tgt5, -1, -1, lat);
        check("match3_lat", 32'(lat), 32'd136);
        check("match3_found", 32'(found), 32'd1);
        check("match3_nonce", nonce_out, 32'd3);
        check("match3_hash", 32'(hash_out), 32'(gold_hash(hdr5, 32'd3)));

        // Top of the nonce space: no wrap.
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            hdr = rand_hdr();
            h0 = gold_hash(hdr, 32'hFFFF_FFFF);
            ok = (h0[23:8] != 16'h0000);
        end
        run(hdr, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0000, -1, -1, lat);
        check("top_lat", 32'(lat), 32'd34);
        check("top_found", 32'(found), 32'd0);
        check("top_nonce", nonce_out, 32'hFFFF_FFFF);

        // Start above limit: exactly one nonce.
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            hdr = rand_hdr();
            h0 = gold_hash(hdr, 32'd10);
            ok = (h0[23:8] != 16'h0000);
        end
        run(hdr, 32'd10, 32'd4, 16'h0000, -1, -1, lat);
        check("inv_lat", 32'(lat), 32'd34);
        check("inv_found", 32'(found), 32'd0);
        check("inv_nonce", nonce_out, 32'd10);

        // start pulsed while busy with different inputs.
        run(hdr5, 32'd0, 32'd10, tgt5, 20, -1, lat);
        check("glitch_lat", 32'(lat), 32'd136);
        check("glitch_found", 32'(found), 32'd1);
        check("glitch_nonce", nonce_out, 32'd3);

        // DONE holds for a few idle cycles (checked by the compare process).
        repeat (5) @(negedge clk);

        // Randomized searches.
        for (int it = 0; it < 12; it++) begin
            hdr = rand_hdr();
            ns  = $urandom;
            nl  = (it == 3) ? ns - 32'd1 : ns + 32'($urandom_range(0, 3));
            tgt = (it % 2 == 1) ? 16'($urandom_range(0, 16'h3FFF)) : 16'($urandom_range(0, 16'hFFFF));
            golden_search(hdr, ns, nl, tgt, n, f);
            run(hdr, ns, nl, tgt, -1, -1, lat);
            check("rnd_lat", 32'(lat), 32'(34 * n));
            check("rnd_found", 32'(found), 32'(f));
            check("rnd_nonce", nonce_out, ns + 32'(n - 1));
            check("rnd_hash", 32'(hash_out), 32'(gold_hash(hdr, ns + 32'(n - 1))));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
